// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port between NREQ
// write-domain requesters, granting bursts of up to MAXBURST beats.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int MAXBURST = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     wr_en,
    output logic [DATASIZE-1:0]      wr_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAXBURST + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBURST - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDXW-1:0]     rr_last_q, rr_last_d;
    logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [DATASIZE-1:0] req_data_arr_s [NREQ];
    logic [IDXW-1:0]     owner_idx_s;
    logic [IDXW:0]       pick_s;
    logic                pick_found_s;
    logic [IDXW-1:0]     pick_idx_s;
    logic                burst_end_s;

    // Scan from last+1 upward (mod NREQ); the nearest requester overwrites the farther ones.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] last);
        logic            found;
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] cand;
        found = 1'b0;
        idx   = {IDXW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            cand  = IDXW'((int'(last) + k) % NREQ);
            found = found | req[cand];
            idx   = req[cand] ? cand : idx;
        end
        return {found, idx};
    endfunction

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | (oh[IDXW'(i)] ? IDXW'(i) : {IDXW{1'b0}});
        end
        return idx;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_data_arr_s[g] = req_data[g*DATASIZE +: DATASIZE];
    end

    // Write-port outputs follow the registered grant; an idle grant selects requester 0's data.
    always_comb begin
        owner_idx_s = onehot_to_idx(gnt_q);
        busy        = (state_q == XFER);
        gnt         = gnt_q;
        req_ready   = gnt_q & {NREQ{~wfull}};
        wr_en       = busy & (|(gnt_q & req_valid)) & ~wfull;
        wr_data     = req_data_arr_s[owner_idx_s];
        burst_end_s = wr_en & (req_last[owner_idx_s] | (beat_cnt_q == CNT_LAST));
        pick_s       = rr_pick(req_valid, rr_last_q);
        pick_found_s = pick_s[IDXW];
        pick_idx_s   = pick_s[IDXW-1:0];
    end

    // Next-state logic: arbitrate in IDLE, count accepted beats in XFER.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d    = XFER;
                    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    beat_cnt_d = {CNTW{1'b0}};
                end else begin
                    state_d    = IDLE;
                end
            end
            XFER: begin
                if (burst_end_s) begin
                    // The owner becomes the lowest priority for the next arbitration.
                    state_d    = IDLE;
                    gnt_d      = {NREQ{1'b0}};
                    rr_last_d  = owner_idx_s;
                    beat_cnt_d = {CNTW{1'b0}};
                end else if (wr_en) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = {NREQ{1'b0}};
                beat_cnt_d = {CNTW{1'b0}};
            end
        endcase
    end

    // State register; reset leaves requester 0 with first priority.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= {NREQ{1'b0}};
            rr_last_q  <= IDX_LAST;
            beat_cnt_q <= {CNTW{1'b0}};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester beat sources, an
// expected-write queue in predicted grant order, and one task per scenario.
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MB    = 16;
    localparam int DEPTH = 256;

    logic              wr_clk   = 1'b0;
    logic              wr_rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wfull    = 1'b0;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [NREQ-1:0]   gnt;
    logic              busy;

    logic [NREQ-1:0]   stall = 4'b0000;
    logic [DW-1:0]     src_data [NREQ][DEPTH];
    logic              src_last [NREQ][DEPTH];
    int                src_wr   [NREQ];
    int                src_rd   [NREQ];
    logic [DW+1:0]     exp_q [$];
    int                checks = 0;
    int                errors = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAXBURST(MB)) dut (
        .wr_clk    (wr_clk),
        .wr_rst_n  (wr_rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    // Each requester presents the head of its source list unless stalled.
    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = (src_rd[i] != src_wr[i]) && !stall[i];
            req_last[i]          = src_last[i][8'(src_rd[i])];
            req_data[i*DW +: DW] = src_data[i][8'(src_rd[i])];
        end
    end

    // Monitor: sample mid-cycle, score every write, then retire accepted beats.
    initial begin : monitor
        logic [NREQ-1:0] hs;
        logic [DW+1:0]   e;
        logic [NREQ-1:0] exp_gnt;
        forever begin
            @(negedge wr_clk);
            hs = req_valid & req_ready & {NREQ{wr_rst_n}};
            checks++;
            if (wr_en && (wfull || !busy)) begin
                errors++;
                $display("FAIL wr_en_guard: wr_en=%b wfull=%b busy=%b, required wr_en=0", wr_en, wfull, busy);
            end
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("FAIL gnt_onehot: gnt=%b, required one-hot or zero", gnt);
            end
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: write data=%h gnt=%b, required no write", wr_data, gnt);
                end else begin
                    e       = exp_q.pop_front();
                    exp_gnt = 4'b0001 << e[DW+1:DW];
                    if (wr_data !== e[DW-1:0] || gnt !== exp_gnt) begin
                        errors++;
                        $display("FAIL sb_beat: data=%h gnt=%b, required data=%h gnt=%b",
                                 wr_data, gnt, e[DW-1:0], exp_gnt);
                    end
                end
            end
            @(posedge wr_clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) src_rd[i] = src_rd[i] + 1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_src(input int i, input logic [DW-1:0] d, input logic l);
        src_data[i][8'(src_wr[i])] = d;
        src_last[i][8'(src_wr[i])] = l;
        src_wr[i] = src_wr[i] + 1;
    endtask

    task automatic push_exp(input int i, input logic [DW-1:0] d);
        exp_q.push_back({2'(i), d});
    endtask

    task automatic step();
        @(posedge wr_clk);
        #2;
    endtask

    task automatic wait_gnt(input string name, input logic [NREQ-1:0] target, input int budget);
        int n;
        n = 0;
        @(negedge wr_clk);
        while (gnt !== target && n < budget) begin
            @(negedge wr_clk);
            n++;
        end
        checks++;
        if (gnt !== target) begin
            errors++;
            $display("FAIL %s_gnt: gnt=%b, required %b", name, gnt, target);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge wr_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        #1 wr_rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            push_src(i, 8'(8'h10 + i), 1'b1);
            push_exp(i, 8'(8'h10 + i));
        end
        repeat (2) @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b busy=%b wr_en=%b req_ready=%b, required all zero",
                     gnt, busy, wr_en, req_ready);
        end
        checks++;
        if (wr_data !== req_data[DW-1:0]) begin
            errors++;
            $display("FAIL reset_wr_data: wr_data=%h, required %h", wr_data, req_data[DW-1:0]);
        end
        step();
        wr_rst_n = 1'b1;
        @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL release_edge: gnt=%b wr_en=%b, required gnt=0000 wr_en=0", gnt, wr_en);
        end
        @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL first_grant: gnt=%b, required 0001", gnt);
        end
        wait_drain("reset", 40);
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [5];
        logic [NREQ-1:0] prev;
        int n, done, we, idle;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step();
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 2; k++) begin
                push_src(b % NREQ, 8'(8'h40 + b*2 + k), k == 1);
                push_exp(b % NREQ, 8'(8'h40 + b*2 + k));
            end
        end
        prev = '0; n = 0; done = 0; we = 0; idle = 0;
        for (int c = 0; c < 80 && done < 5; c++) begin
            @(negedge wr_clk);
            if (gnt != 4'b0000) begin
                if (prev == 4'b0000) begin
                    if (n > 0) begin
                        checks++;
                        if (idle != 1) begin
                            errors++;
                            $display("FAIL rr_bubble: idle cycles=%0d, required 1", idle);
                        end
                    end
                    checks++;
                    if (n < 5 && gnt !== exp_g[n]) begin
                        errors++;
                        $display("FAIL rr_order: grant %0d gnt=%b, required %b", n, gnt, exp_g[n]);
                    end
                    n++;
                    we = 0;
                end
                if (wr_en) we++;
            end else begin
                if (prev != 4'b0000) begin
                    checks++;
                    if (we != 2) begin
                        errors++;
                        $display("FAIL rr_beats: writes=%0d, required 2", we);
                    end
                    done++;
                    idle = 0;
                end
                idle++;
            end
            prev = gnt;
        end
        checks++;
        if (done != 5) begin
            errors++;
            $display("FAIL rr_timeout: bursts=%0d, required 5", done);
        end
        wait_drain("rr", 20);
    endtask

    task automatic test_max_burst();
        int cnt, n;
        step();
        for (int k = 0; k < 20; k++) begin
            push_src(2, 8'(8'h60 + k), k == 19);
            if (k < MB) push_exp(2, 8'(8'h60 + k));
        end
        push_src(3, 8'h90, 1'b0);
        push_src(3, 8'h91, 1'b1);
        push_exp(3, 8'h90);
        push_exp(3, 8'h91);
        for (int k = MB; k < 20; k++) push_exp(2, 8'(8'h60 + k));
        wait_gnt("maxburst", 4'b0100, 10);
        cnt = 0; n = 0;
        while (gnt === 4'b0100 && n < 40) begin
            if (wr_en) cnt++;
            @(negedge wr_clk);
            n++;
        end
        checks++;
        if (cnt != MB) begin
            errors++;
            $display("FAIL maxburst_beats: writes=%0d, required %0d", cnt, MB);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL maxburst_bubble: gnt=%b, required 0000", gnt);
        end
        @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL maxburst_next: gnt=%b, required 1000", gnt);
        end
        wait_drain("maxburst", 60);
    endtask

    task automatic test_backpressure();
        step();
        for (int k = 0; k < 8; k++) begin
            push_src(1, 8'(8'hA0 + k), k == 7);
            push_exp(1, 8'(8'hA0 + k));
        end
        wait_gnt("bp", 4'b0010, 10);
        repeat (2) @(negedge wr_clk);
        step();
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge wr_clk);
            checks++;
            if (wr_en !== 1'b0 || req_ready !== 4'b0000 || gnt !== 4'b0010 || dut.beat_cnt_q !== 5'd3) begin
                errors++;
                $display("FAIL bp_hold: wr_en=%b req_ready=%b gnt=%b beat_cnt=%0d, required 0 0000 0010 3",
                         wr_en, req_ready, gnt, dut.beat_cnt_q);
            end
        end
        step();
        wfull = 1'b0;
        wait_drain("bp", 40);
    endtask

    task automatic test_owner_stall();
        step();
        for (int k = 0; k < 6; k++) begin
            push_src(0, 8'(8'hC0 + k), k == 5);
            push_exp(0, 8'(8'hC0 + k));
        end
        push_src(1, 8'hD0, 1'b0);
        push_src(1, 8'hD1, 1'b1);
        push_exp(1, 8'hD0);
        push_exp(1, 8'hD1);
        wait_gnt("stall", 4'b0001, 10);
        @(negedge wr_clk);
        step();
        stall[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge wr_clk);
            checks++;
            if (gnt !== 4'b0001 || wr_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: gnt=%b wr_en=%b busy=%b, required 0001 0 1", gnt, wr_en, busy);
            end
        end
        step();
        stall[0] = 1'b0;
        wait_gnt("stall_end", 4'b0000, 20);
        wait_gnt("stall_next", 4'b0010, 0);
        wait_drain("stall", 40);
    endtask

    task automatic test_reset_midburst();
        step();
        for (int k = 0; k < 3; k++) push_exp(2, 8'(8'hE0 + k));
        push_exp(0, 8'hF0);
        for (int k = 3; k < 8; k++) push_exp(2, 8'(8'hE0 + k));
        for (int k = 0; k < 8; k++) push_src(2, 8'(8'hE0 + k), k == 7);
        push_src(0, 8'hF0, 1'b1);
        wait_gnt("rst_mid", 4'b0100, 10);
        repeat (2) @(negedge wr_clk);
        step();
        wr_rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: gnt=%b busy=%b wr_en=%b, required 0000 0 0", gnt, busy, wr_en);
        end
        step();
        step();
        wr_rst_n = 1'b1;
        @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_release: gnt=%b, required 0000", gnt);
        end
        @(negedge wr_clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_restart: gnt=%b, required 0001", gnt);
        end
        wait_drain("rst_mid", 40);
    endtask

    initial begin : main
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_owner_stall();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
